// File: rtl/logic_unit_n.sv
// Multi-cycle logic unit: one-cycle bitwise ops, rotates stepped one bit per cycle.
// Optional registered Zero flag is enabled by defining LOGIC_ZERO_FLAG_EN.
module logic_unit_n #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       AluOp,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic             Zero
`endif
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic [SHW-1:0]     cnt_reg, cnt_next;
    logic               dir_reg, dir_next;      // 0 = left, 1 = right
    logic [WIDTH-1:0]   result_reg, result_next;

    logic [WIDTH-1:0]   bit_res;
    logic [WIDTH-1:0]   rol_one;
    logic [WIDTH-1:0]   ror_one;
    logic [WIDTH-1:0]   step_res;
    logic [SHW-1:0]     rot_amt;
    logic               is_rot;

    assign rot_amt = B[SHW-1:0];
    assign is_rot  = (AluOp == OP_ROL) || (AluOp == OP_ROR);

    // Per-bit operation slice; rotate opcodes pass A so a zero-amount rotate completes here.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitop
            always_comb begin
                bit_res[gi] = 1'b0;
                case (AluOp)
                    OP_NOT:  bit_res[gi] = ~A[gi];
                    OP_AND:  bit_res[gi] = A[gi] & B[gi];
                    OP_OR:   bit_res[gi] = A[gi] | B[gi];
                    OP_NAND: bit_res[gi] = ~(A[gi] & B[gi]);
                    OP_ROL:  bit_res[gi] = A[gi];
                    OP_ROR:  bit_res[gi] = A[gi];
                    OP_XOR:  bit_res[gi] = A[gi] ^ B[gi];
                    OP_XNOR: bit_res[gi] = ~(A[gi] ^ B[gi]);
                    default: bit_res[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Single-bit rotate of the working register, wrapping MSB<->LSB.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rol_one[gi] = work_reg[(gi + WIDTH - 1) % WIDTH];
            assign ror_one[gi] = work_reg[(gi + 1) % WIDTH];
        end
    endgenerate

    assign step_res = dir_reg ? ror_one : rol_one;

    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        dir_next    = dir_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (InValid) begin
                    if (is_rot && (rot_amt != '0)) begin
                        work_next  = A;
                        cnt_next   = rot_amt;
                        dir_next   = (AluOp == OP_ROR);
                        state_next = ROT;
                    end else begin
                        result_next = bit_res;
                        state_next  = HOLD;
                    end
                end
            end
            ROT: begin
                work_next = step_res;
                cnt_next  = cnt_reg - SHW'(1);
                // Last rotation publishes directly so Result never shows partial values.
                if (cnt_reg == SHW'(1)) begin
                    result_next = step_res;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg  <= IDLE;
            work_reg   <= '0;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            dir_reg    <= dir_next;
            result_reg <= result_next;
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            zero_reg <= 1'b1;
        end else begin
            zero_reg <= (result_next == '0);
        end
    end

    assign Zero = zero_reg;
`endif

    assign InReady  = (state_reg == IDLE);
    assign OutValid = (state_reg == HOLD);
    assign Result   = result_reg;

endmodule

// File: tb/tb_logic_unit_n.sv
// Directed bench for logic_unit_n (WIDTH=8): latency, results, handshake, reset abort.
// Zero-flag checks are compiled in when LOGIC_ZERO_FLAG_EN is defined.
module tb_logic_unit_n;

    logic       Clk;
    logic       Rst;
    logic       InValid;
    logic       InReady;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] AluOp;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] Result;
`ifdef LOGIC_ZERO_FLAG_EN
    logic       Zero;
`endif

    int checks = 0;
    int errors = 0;

    logic_unit_n #(.WIDTH(8)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .AluOp    (AluOp),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result)
`ifdef LOGIC_ZERO_FLAG_EN
        ,
        .Zero     (Zero)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request, hold it only on the accept edge, measure latency, then hand off.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
        int lat;
        logic [7:0] prev;
        prev = Result;
        @(negedge Clk);
        AluOp   = op;
        A       = a;
        B       = b;
        InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        lat = 1;
        while (!OutValid && lat < 40) begin
            check_eq({tag, "_busy_ready"}, {31'd0, InReady}, 32'd0);
            check_eq({tag, "_busy_result"}, {24'd0, Result}, {24'd0, prev});
            @(posedge Clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_result"}, {24'd0, Result}, {24'd0, exp});
        check_eq({tag, "_hold_ready"}, {31'd0, InReady}, 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
        check_eq({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp == 8'h00)});
`endif
        @(negedge Clk);
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        check_eq({tag, "_done_ready"}, {31'd0, InReady}, 32'd1);
        check_eq({tag, "_done_valid"}, {31'd0, OutValid}, 32'd0);
        check_eq({tag, "_retain"}, {24'd0, Result}, {24'd0, exp});
        $display("op %s AluOp=%b A=%h B=%h -> Result=%h latency=%0d", tag, op, a, b, Result, lat);
    endtask

    initial begin
        Rst      = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        AluOp    = 3'b000;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_ready", {31'd0, InReady}, 32'd1);
        check_eq("rst_valid", {31'd0, OutValid}, 32'd0);
        check_eq("rst_result", {24'd0, Result}, 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
        check_eq("rst_zero", {31'd0, Zero}, 32'd1);
`endif
        @(negedge Clk);
        Rst = 1'b0;

        run_op("and",     3'b001, 8'hF0, 8'h3C, 8'h30, 1);
        run_op("rol3",    3'b100, 8'h81, 8'h03, 8'h0C, 4);
        run_op("ror1",    3'b101, 8'h01, 8'h09, 8'h80, 2);
        run_op("rol0",    3'b100, 8'h5A, 8'h00, 8'h5A, 1);
        run_op("nand",    3'b011, 8'hFF, 8'hFF, 8'h00, 1);
        run_op("xor",     3'b110, 8'hAA, 8'hFF, 8'h55, 1);
        run_op("not",     3'b000, 8'h0F, 8'h33, 8'hF0, 1);
        run_op("or",      3'b010, 8'hA0, 8'h05, 8'hA5, 1);
        run_op("xnor",    3'b111, 8'hA5, 8'h0F, 8'h55, 1);
        run_op("ror7",    3'b101, 8'h81, 8'h07, 8'h03, 8);
        run_op("rol7",    3'b100, 8'h80, 8'hFF, 8'h40, 8);
        run_op("ror0",    3'b101, 8'hC3, 8'hF8, 8'hC3, 1);

        // Stall in HOLD with a competing request present.
        @(negedge Clk);
        AluOp   = 3'b001;
        A       = 8'hFF;
        B       = 8'h0F;
        InValid = 1'b1;
        @(posedge Clk);
        #1;
        A     = 8'h00;
        AluOp = 3'b010;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", {31'd0, OutValid}, 32'd1);
            check_eq("stall_ready", {31'd0, InReady}, 32'd0);
            check_eq("stall_result", {24'd0, Result}, 32'h0F);
            @(posedge Clk);
            #1;
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        check_eq("stall_release_ready", {31'd0, InReady}, 32'd1);
        check_eq("stall_release_valid", {31'd0, OutValid}, 32'd0);
        check_eq("stall_release_result", {24'd0, Result}, 32'h0F);
        $display("op stall AluOp=001 A=ff B=0f -> Result=%h held 5 cycles", Result);

        // Reset in the middle of a long rotate.
        @(negedge Clk);
        AluOp   = 3'b100;
        A       = 8'h81;
        B       = 8'h07;
        InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("midrot_valid", {31'd0, OutValid}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check_eq("abort_ready", {31'd0, InReady}, 32'd1);
        check_eq("abort_valid", {31'd0, OutValid}, 32'd0);
        check_eq("abort_result", {24'd0, Result}, 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
        check_eq("abort_zero", {31'd0, Zero}, 32'd1);
`endif
        @(negedge Clk);
        Rst = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check_eq("abort_no_output", {31'd0, OutValid}, 32'd0);
        $display("op abort AluOp=100 A=81 B=07 -> Result=%h after reset", Result);

        run_op("post_rst", 3'b110, 8'h3C, 8'h0F, 8'h33, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
